cache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Responds to the per-cycle request stream (valid/write/addr) produced by the instruction-sequence ROM and bench drivers.
- Holds tag, valid, dirty and data arrays.
- Stalls the requester on a miss and runs whole-line write-back and fill transactions on a simple cs/we/ack memory port.

---
 rtl/cache_ctrl_if.sv | 35 +++
 rtl/cache_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU request/response and line-memory signals of cache_ctrl.
//   cpu_valid/cpu_write/cpu_addr/cpu_din : request from the requester
//   cpu_dout/cpu_stall                   : load data and stall back to the requester
//   mem_cs/mem_we/mem_addr/mem_dout      : line transaction towards memory
//   mem_din/mem_ack                      : fill line and completion pulse from memory
// Modports: slave = controller view, master = requester/memory environment view.
interface cache_ctrl_if #(
  parameter int unsigned WORD_BITS = 2
) ();
  localparam int unsigned LINE_W = 32 * (1 << WORD_BITS);

  logic              cpu_valid;
  logic              cpu_write;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_din;
  logic [31:0]       cpu_dout;
  logic              cpu_stall;

  logic              mem_cs;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_dout;
  logic [LINE_W-1:0] mem_din;
  logic              mem_ack;

  modport slave (
    input  cpu_valid, cpu_write, cpu_addr, cpu_din, mem_din, mem_ack,
    output cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_dout
  );

  modport master (
    output cpu_valid, cpu_write, cpu_addr, cpu_din, mem_din, mem_ack,
    input  cpu_dout, cpu_stall, mem_cs, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : cache_ctrl_if.slave (CPU request/response + line memory port)
//   hit_count, miss_count : 32-bit statistics, present only with CACHE_STATS_EN
// Optional feature macro: CACHE_STATS_EN (adds hit/miss counters).
// cpu_dout/cpu_stall are combinational (same-cycle hit data and miss stall);
// memory-side outputs are registered and change only on state transitions.
module cache_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned WORD_BITS  = 2
) (
  input  logic         clk,
  input  logic         rst,
  cache_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned LINES  = 1 << INDEX_BITS;
  localparam int unsigned WORDS  = 1 << WORD_BITS;
  localparam int unsigned LINE_W = 32 * WORDS;
  localparam int unsigned OFF_W  = WORD_BITS + 2;
  localparam int unsigned TAG_W  = 32 - OFF_W - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                       state;
  logic [TAG_W-1:0]             tag_arr  [LINES];
  logic [WORDS-1:0][31:0]       data_arr [LINES];
  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             dirty_q;
  logic [TAG_W-1:0]             req_tag;
  logic [INDEX_BITS-1:0]        req_index;

  logic                         mem_cs_q;
  logic                         mem_we_q;
  logic [31:0]                  mem_addr_q;
  logic [LINE_W-1:0]            mem_dout_q;

  logic [TAG_W-1:0]             cpu_tag;
  logic [INDEX_BITS-1:0]        cpu_index;
  logic [WORD_BITS-1:0]         cpu_word;
  logic                         hit;
  logic                         idle_hit;
  logic                         idle_miss;
  logic [1:0]                   unused_byte_bits;

  // Address split; byte-offset bits are don't-care.
  assign cpu_tag          = bus.cpu_addr[31 -: TAG_W];
  assign cpu_index        = bus.cpu_addr[OFF_W +: INDEX_BITS];
  assign cpu_word         = bus.cpu_addr[2 +: WORD_BITS];
  assign unused_byte_bits = bus.cpu_addr[1:0];

  // Lookup and request classification.
  always_comb begin
    hit       = bus.cpu_valid & valid_q[cpu_index] & (tag_arr[cpu_index] == cpu_tag);
    idle_hit  = (state == S_IDLE) & hit;
    idle_miss = (state == S_IDLE) & bus.cpu_valid & ~hit;
  end

  // CPU-facing outputs: zero data unless a load hits in S_IDLE.
  always_comb begin
    bus.cpu_dout  = '0;
    bus.cpu_stall = (state != S_IDLE) | idle_miss;
    if (idle_hit && !bus.cpu_write) begin
      bus.cpu_dout = data_arr[cpu_index][cpu_word];
    end
  end

  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_dout = mem_dout_q;

  // Controller FSM, valid/dirty bits, request latch and registered memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      req_tag    <= '0;
      req_index  <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_hit && bus.cpu_write) begin
            dirty_q[cpu_index] <= 1'b1;
          end else if (idle_miss) begin
            req_tag   <= cpu_tag;
            req_index <= cpu_index;
            mem_cs_q  <= 1'b1;
            if (valid_q[cpu_index] && dirty_q[cpu_index]) begin
              // Victim goes out first, addressed by its own stored tag.
              state      <= S_WB;
              mem_we_q   <= 1'b1;
              mem_addr_q <= {tag_arr[cpu_index], cpu_index, OFF_W'(0)};
              mem_dout_q <= data_arr[cpu_index];
            end else begin
              state      <= S_FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {cpu_tag, cpu_index, OFF_W'(0)};
              mem_dout_q <= '0;
            end
          end
        end
        S_WB: begin
          if (bus.mem_ack) begin
            state      <= S_FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag, req_index, OFF_W'(0)};
            mem_dout_q <= '0;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            state              <= S_IDLE;
            valid_q[req_index] <= 1'b1;
            dirty_q[req_index] <= 1'b0;
            mem_cs_q           <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= '0;
            mem_dout_q         <= '0;
          end
        end
        default: begin
          state      <= S_IDLE;
          mem_cs_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_addr_q <= '0;
          mem_dout_q <= '0;
        end
      endcase
    end
  end

  // Tag and data storage; contents survive reset, writes are blocked during it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_hit && bus.cpu_write) begin
        data_arr[cpu_index][cpu_word] <= bus.cpu_din;
      end else if (state == S_FILL && bus.mem_ack) begin
        data_arr[req_index] <= bus.mem_din;
        tag_arr[req_index]  <= req_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic post_fill;

  // Hit/miss statistics; the re-evaluation hit right after a fill is not a new hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      post_fill  <= 1'b0;
    end else begin
      if (state == S_FILL && bus.mem_ack) begin
        post_fill <= 1'b1;
      end else if (state == S_IDLE) begin
        post_fill <= 1'b0;
      end
      if (idle_hit && !post_fill) begin
        hit_count <= hit_count + 32'd1;
      end
      if (idle_miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl.
module tb_cache_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_ctrl_if #(.WORD_BITS(2)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_ctrl #(
    .INDEX_BITS(4),
    .WORD_BITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_valid = v;
    bus.cpu_write = w;
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
  endtask

  // Clean miss: one IDLE miss cycle, fill (with lat extra wait cycles), ack.
  task automatic miss_fill(input string tag, input logic [31:0] faddr,
                           input logic [127:0] line, input int lat);
    @(negedge clk);
    chk({tag, "_miss_stall"}, 128'(bus.cpu_stall), 128'(1'b1));
    chk({tag, "_miss_cs"},    128'(bus.mem_cs),    128'(1'b0));
    tick();
    @(negedge clk);
    chk({tag, "_fill_cs"},    128'(bus.mem_cs),    128'(1'b1));
    chk({tag, "_fill_we"},    128'(bus.mem_we),    128'(1'b0));
    chk({tag, "_fill_addr"},  128'(bus.mem_addr),  128'(faddr));
    for (int i = 0; i < lat; i++) begin
      tick();
      @(negedge clk);
      chk({tag, "_wait_stall"}, 128'(bus.cpu_stall), 128'(1'b1));
      chk({tag, "_wait_cs"},    128'(bus.mem_cs),    128'(1'b1));
    end
    bus.mem_din = line;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
  endtask

  // Dirty miss: one IDLE miss cycle, write-back, fill.
  task automatic miss_wb_fill(input string tag, input logic [31:0] wbaddr,
                              input logic [127:0] wbline, input logic [31:0] faddr,
                              input logic [127:0] fline);
    @(negedge clk);
    chk({tag, "_miss_stall"}, 128'(bus.cpu_stall), 128'(1'b1));
    chk({tag, "_miss_cs"},    128'(bus.mem_cs),    128'(1'b0));
    tick();
    @(negedge clk);
    chk({tag, "_wb_cs"},      128'(bus.mem_cs),    128'(1'b1));
    chk({tag, "_wb_we"},      128'(bus.mem_we),    128'(1'b1));
    chk({tag, "_wb_addr"},    128'(bus.mem_addr),  128'(wbaddr));
    chk({tag, "_wb_dout"},    bus.mem_dout,        wbline);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_fill_cs"},    128'(bus.mem_cs),    128'(1'b1));
    chk({tag, "_fill_we"},    128'(bus.mem_we),    128'(1'b0));
    chk({tag, "_fill_addr"},  128'(bus.mem_addr),  128'(faddr));
    chk({tag, "_fill_stall"}, 128'(bus.cpu_stall), 128'(1'b1));
    bus.mem_din = fline;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
  endtask

  logic [127:0] l0, l1, l2, l3, l1_wb, l3_wb, l1_dirty;

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    l0       = {32'd4, 32'd3, 32'd2, 32'd1};
    l1       = {32'h14, 32'h13, 32'h12, 32'h11};
    l2       = {32'h24, 32'h23, 32'h22, 32'h21};
    l3       = {32'h34, 32'h33, 32'h32, 32'h31};
    l1_wb    = {32'h14, 32'hAA, 32'h55, 32'h11};
    l3_wb    = {32'h34, 32'hBB, 32'h32, 32'h31};
    l1_dirty = {32'h77, 32'hAA, 32'h55, 32'h11};
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_din = '0;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("rst_cs",    128'(bus.mem_cs),    128'(1'b0));
    chk("rst_dout",  128'(bus.cpu_dout),  128'(32'h0));
    chk("rst_addr",  128'(bus.mem_addr),  128'(32'h0));

    // Load 0x4: clean miss, fill of line 0, then word 1 = 2.
    tick();
    drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    miss_fill("ld4", 32'h0000_0000, l0, 0);
    @(negedge clk);
    chk("ld4_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("ld4_dout",  128'(bus.cpu_dout),  128'(32'd2));
    chk("ld4_cs",    128'(bus.mem_cs),    128'(1'b0));

    // Store 0x18 = 0xAA: clean miss with slow memory, then store hits.
    tick();
    drive(1'b1, 1'b1, 32'h0000_0018, 32'hAA);
    miss_fill("st18", 32'h0000_0010, l1, 2);
    @(negedge clk);
    chk("st18_stall", 128'(bus.cpu_stall), 128'(1'b0));

    // Load 0x8: one-cycle hit.
    tick();
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    chk("ld8_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("ld8_dout",  128'(bus.cpu_dout),  128'(32'd3));

    // Store 0x14 = 0x55: one-cycle hit.
    tick();
    drive(1'b1, 1'b1, 32'h0000_0014, 32'h55);
    @(negedge clk);
    chk("st14_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("st14_dout",  128'(bus.cpu_dout),  128'(32'h0));

    // Load 0x10000004: conflict on clean index 0, no write-back.
    tick();
    drive(1'b1, 1'b0, 32'h1000_0004, 32'h0);
    miss_fill("ld1004", 32'h1000_0000, l2, 0);
    @(negedge clk);
    chk("ld1004_dout", 128'(bus.cpu_dout), 128'(32'h22));

    // Store 0x10000018 = 0xBB: dirty index 1 written back first.
    tick();
    drive(1'b1, 1'b1, 32'h1000_0018, 32'hBB);
    miss_wb_fill("st1018", 32'h0000_0010, l1_wb, 32'h1000_0010, l3);
    @(negedge clk);
    chk("st1018_stall", 128'(bus.cpu_stall), 128'(1'b0));
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("idle_dout",  128'(bus.cpu_dout),  128'(32'h0));
`ifdef CACHE_STATS_EN
    chk("seq_hits",   128'(hit_count),  128'(32'd2));
    chk("seq_misses", 128'(miss_count), 128'(32'd4));
`endif

    // Load 0x18: proves dirty[1] and the 0xBB store via the write-back line.
    tick();
    drive(1'b1, 1'b0, 32'h0000_0018, 32'h0);
    miss_wb_fill("ld18", 32'h1000_0010, l3_wb, 32'h0000_0010, l1_wb);
    @(negedge clk);
    chk("ld18_dout", 128'(bus.cpu_dout), 128'(32'hAA));

    // Store 0x1C = 0x77 hits and dirties index 1.
    tick();
    drive(1'b1, 1'b1, 32'h0000_001C, 32'h77);
    @(negedge clk);
    chk("st1c_stall", 128'(bus.cpu_stall), 128'(1'b0));

    // Load 0x20000010: dirty miss; reset while write-back is pending.
    tick();
    drive(1'b1, 1'b0, 32'h2000_0010, 32'h0);
    @(negedge clk);
    chk("ld2010_stall", 128'(bus.cpu_stall), 128'(1'b1));
    tick();
    @(negedge clk);
    chk("ld2010_wb_cs",   128'(bus.mem_cs),   128'(1'b1));
    chk("ld2010_wb_we",   128'(bus.mem_we),   128'(1'b1));
    chk("ld2010_wb_addr", 128'(bus.mem_addr), 128'(32'h0000_0010));
    chk("ld2010_wb_dout", bus.mem_dout,       l1_dirty);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs",    128'(bus.mem_cs),    128'(1'b0));
    chk("mid_rst_we",    128'(bus.mem_we),    128'(1'b0));
    chk("mid_rst_stall", 128'(bus.cpu_stall), 128'(1'b0));
    chk("mid_rst_dout",  128'(bus.cpu_dout),  128'(32'h0));
`ifdef CACHE_STATS_EN
    chk("rst_hits",   128'(hit_count),  128'(32'd0));
    chk("rst_misses", 128'(miss_count), 128'(32'd0));
`endif
    // Late ack after reset must be ignored.
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_cs",    128'(bus.mem_cs),    128'(1'b0));
    chk("late_ack_stall", 128'(bus.cpu_stall), 128'(1'b0));

    // Load 0x1C: index 1 was dirty before reset; now a plain fill.
    tick();
    drive(1'b1, 1'b0, 32'h0000_001C, 32'h0);
    miss_fill("ld1c", 32'h0000_0010, l1_wb, 0);
    @(negedge clk);
    chk("ld1c_dout", 128'(bus.cpu_dout), 128'(32'h14));

    // Load 0x4 misses because valid bits were cleared.
    tick();
    drive(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    miss_fill("ld4b", 32'h0000_0000, l0, 1);
    @(negedge clk);
    chk("ld4b_dout", 128'(bus.cpu_dout), 128'(32'd2));
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("end_cs", 128'(bus.mem_cs), 128'(1'b0));
`ifdef CACHE_STATS_EN
    chk("end_hits",   128'(hit_count),  128'(32'd0));
    chk("end_misses", 128'(miss_count), 128'(32'd2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
